sequence_detect_mealy: RTL and testbench

Mealy-style serial pattern detector: samples one bit `x` per rising edge of `clk` and asserts `y` combinationally during the cycle in which the final bit of the configured pattern is present on `x`. The block is a leaf in the control path, fed by a serial bit stream and driving downstream event logic. It has one clock and a synchronous clear. Pattern, length and overlap mode are elaboration-time parameters, and the state transition table is derived generically from them.

---
 rtl/sequence_detect_mealy.sv | 94 +++++++++
 tb/tb_sequence_detect_mealy.sv | 110 +++++++++++
 2 files changed

// File: rtl/sequence_detect_mealy.sv
// Mealy serial pattern detector. The transition table is derived from PATTERN and
// OVERLAP at elaboration; y flags the cycle in which the final pattern bit is on x.
module sequence_detect_mealy #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
    parameter bit                 OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic clr,
    input  logic x,
    output logic y
);

    localparam int SW = $clog2(PAT_LEN);
    localparam int NS = 1 << SW;

    typedef enum logic [SW-1:0] {
        S0 = '0
    } stateT;

    localparam stateT LAST = stateT'(SW'(PAT_LEN - 1));

    // Longest pattern prefix that is a suffix of (first k pattern bits + b), capped
    // below PAT_LEN so that a full match falls back to its KMP failure value.
    function automatic int nextStateOf(input int k, input logic b);
        logic [16:0] s;
        int          maxJ;
        int          best;
        bit          ok;
        s = '0;
        for (int i = 0; i < k; i++) begin
            s[i] = PATTERN[PAT_LEN-1-i];
        end
        s[k] = b;
        maxJ = (k + 1 < PAT_LEN) ? k + 1 : PAT_LEN - 1;
        best = 0;
        for (int j = 1; j <= maxJ; j++) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++) begin
                if (PATTERN[PAT_LEN-1-i] != s[k+1-j+i]) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                best = j;
            end
        end
        return best;
    endfunction

    stateT r_state;
    stateT w_next;
    stateT w_nextOn0 [NS];
    stateT w_nextOn1 [NS];

    if (PAT_LEN < 2 || PAT_LEN > 16) begin : gBadLen
        $error("sequence_detect_mealy: PAT_LEN must be in 2..16");
    end

    // Encodings beyond S(PAT_LEN-1) are unreachable and route back to S0.
    for (genvar k = 0; k < NS; k++) begin : gTable
        if (k < PAT_LEN) begin : gLive
            localparam bit FULL0 = (k == PAT_LEN - 1) && (PATTERN[0] == 1'b0);
            localparam bit FULL1 = (k == PAT_LEN - 1) && (PATTERN[0] == 1'b1);
            localparam int N0    = (FULL0 && !OVERLAP) ? 0 : nextStateOf(k, 1'b0);
            localparam int N1    = (FULL1 && !OVERLAP) ? 0 : nextStateOf(k, 1'b1);
            assign w_nextOn0[k] = stateT'(SW'(N0));
            assign w_nextOn1[k] = stateT'(SW'(N1));
        end else begin : gDead
            assign w_nextOn0[k] = S0;
            assign w_nextOn1[k] = S0;
        end
    end

    always_comb begin
        w_next = S0;
        y      = 1'b0;
        if (!clr) begin
            w_next = x ? w_nextOn1[r_state] : w_nextOn0[r_state];
            if (r_state == LAST && x == PATTERN[0]) begin
                y = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S0;
        end else begin
            r_state <= w_next;
        end
    end

endmodule

// File: tb/tb_sequence_detect_mealy.sv
// Directed bench for sequence_detect_mealy: default pattern with and without
// overlap, plus a 3-bit 010 variant, checking y in the cycle each bit is presented.
module tb_sequence_detect_mealy;

    logic clk = 1'b0;
    logic clr;
    logic xAB;
    logic xC;
    logic yA;
    logic yB;
    logic yC;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sequence_detect_mealy #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b1)) dutA (
        .clk(clk), .clr(clr), .x(xAB), .y(yA)
    );

    sequence_detect_mealy #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b0)) dutB (
        .clk(clk), .clr(clr), .x(xAB), .y(yB)
    );

    sequence_detect_mealy #(.PAT_LEN(3), .PATTERN(3'b010), .OVERLAP(1'b1)) dutC (
        .clk(clk), .clr(clr), .x(xC), .y(yC)
    );

    // Inputs change just after a falling edge; y is observed 1 ns later,
    // well before the rising edge that consumes the bit.
    task automatic applyStimulus(input logic c, input logic b, input logic bc);
        @(negedge clk);
        clr = c;
        xAB = b;
        xC  = bc;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    initial begin
        clr = 1'b1;
        xAB = 1'b0;
        xC  = 1'b0;

        // clr held for 7 cycles, y must stay low whatever x does
        applyStimulus(1, 0, 0); checkOutput("clr0 A", yA, 0); checkOutput("clr0 B", yB, 0);
        applyStimulus(1, 0, 0); checkOutput("clr1 A", yA, 0); checkOutput("clr1 B", yB, 0);
        applyStimulus(1, 1, 0); checkOutput("clr2 A", yA, 0); checkOutput("clr2 B", yB, 0);
        applyStimulus(1, 1, 0); checkOutput("clr3 A", yA, 0); checkOutput("clr3 B", yB, 0);
        applyStimulus(1, 0, 0); checkOutput("clr4 A", yA, 0); checkOutput("clr4 B", yB, 0);
        applyStimulus(1, 0, 0); checkOutput("clr5 A", yA, 0); checkOutput("clr5 B", yB, 0);
        applyStimulus(1, 0, 0); checkOutput("clr6 A", yA, 0); checkOutput("clr6 B", yB, 0);

        // first match after release: 1,1,0,1
        applyStimulus(0, 1, 0); checkOutput("rel1 A", yA, 0); checkOutput("rel1 B", yB, 0);
        applyStimulus(0, 1, 0); checkOutput("rel2 A", yA, 0); checkOutput("rel2 B", yB, 0);
        applyStimulus(0, 0, 0); checkOutput("rel3 A", yA, 0); checkOutput("rel3 B", yB, 0);
        applyStimulus(0, 1, 0); checkOutput("rel4 A", yA, 1); checkOutput("rel4 B", yB, 1);

        // overlap: 1,1,0,1,1,0,1 -> A hits bits 4 and 7, B only bit 4
        applyStimulus(1, 0, 0); checkOutput("ovc A", yA, 0); checkOutput("ovc B", yB, 0);
        applyStimulus(0, 1, 0); checkOutput("ov1 A", yA, 0); checkOutput("ov1 B", yB, 0);
        applyStimulus(0, 1, 0); checkOutput("ov2 A", yA, 0); checkOutput("ov2 B", yB, 0);
        applyStimulus(0, 0, 0); checkOutput("ov3 A", yA, 0); checkOutput("ov3 B", yB, 0);
        applyStimulus(0, 1, 0); checkOutput("ov4 A", yA, 1); checkOutput("ov4 B", yB, 1);
        applyStimulus(0, 1, 0); checkOutput("ov5 A", yA, 0); checkOutput("ov5 B", yB, 0);
        applyStimulus(0, 0, 0); checkOutput("ov6 A", yA, 0); checkOutput("ov6 B", yB, 0);
        applyStimulus(0, 1, 0); checkOutput("ov7 A", yA, 1); checkOutput("ov7 B", yB, 0);

        // mismatch recovery: 1,1,1,0,1 -> S2 self-loops, hit on bit 5
        applyStimulus(1, 0, 0); checkOutput("mmc A", yA, 0); checkOutput("mmc B", yB, 0);
        applyStimulus(0, 1, 0); checkOutput("mm1 A", yA, 0); checkOutput("mm1 B", yB, 0);
        applyStimulus(0, 1, 0); checkOutput("mm2 A", yA, 0); checkOutput("mm2 B", yB, 0);
        applyStimulus(0, 1, 0); checkOutput("mm3 A", yA, 0); checkOutput("mm3 B", yB, 0);
        applyStimulus(0, 0, 0); checkOutput("mm4 A", yA, 0); checkOutput("mm4 B", yB, 0);
        applyStimulus(0, 1, 0); checkOutput("mm5 A", yA, 1); checkOutput("mm5 B", yB, 1);

        // clear mid-pattern: 1,1,0 then clr with the completing 1, then 1,1,0,1
        applyStimulus(1, 0, 0); checkOutput("mpc A", yA, 0); checkOutput("mpc B", yB, 0);
        applyStimulus(0, 1, 0); checkOutput("mp1 A", yA, 0); checkOutput("mp1 B", yB, 0);
        applyStimulus(0, 1, 0); checkOutput("mp2 A", yA, 0); checkOutput("mp2 B", yB, 0);
        applyStimulus(0, 0, 0); checkOutput("mp3 A", yA, 0); checkOutput("mp3 B", yB, 0);
        applyStimulus(1, 1, 0); checkOutput("mpclr A", yA, 0); checkOutput("mpclr B", yB, 0);
        applyStimulus(0, 1, 0); checkOutput("mp5 A", yA, 0); checkOutput("mp5 B", yB, 0);
        applyStimulus(0, 1, 0); checkOutput("mp6 A", yA, 0); checkOutput("mp6 B", yB, 0);
        applyStimulus(0, 0, 0); checkOutput("mp7 A", yA, 0); checkOutput("mp7 B", yB, 0);
        applyStimulus(0, 1, 0); checkOutput("mp8 A", yA, 1); checkOutput("mp8 B", yB, 1);

        // 3-bit pattern 010 with overlap: 0,1,0,1,0 -> hits on bits 3 and 5
        applyStimulus(1, 0, 1); checkOutput("c clr", yC, 0); checkOutput("c clr A", yA, 0);
        applyStimulus(0, 0, 0); checkOutput("c1", yC, 0); checkOutput("c1 A", yA, 0);
        applyStimulus(0, 0, 1); checkOutput("c2", yC, 0);
        applyStimulus(0, 0, 0); checkOutput("c3", yC, 1); checkOutput("c3 A", yA, 0);
        applyStimulus(0, 0, 1); checkOutput("c4", yC, 0);
        applyStimulus(0, 0, 0); checkOutput("c5", yC, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
